if_fetch: RTL and testbench

- Instruction-fetch (IF) stage of the 5-stage MIPS pipeline; producer end of the IF→ID interface and consumer of the branch bus that ID drives back.
- Owns the PC register and drives the synchronous instruction SRAM request.
- Packs {ce, pc} onto if_to_id_bus; ID samples inst_sram_rdata one cycle later.
- Honours the stall vector and holds branch redirects that arrive while IF is stalled, so no redirect is lost.

---
 rtl/if_fetch_pkg.sv | 30 +++
 rtl/if_fetch_pc_redirect.sv | 41 ++++
 rtl/if_fetch.sv | 66 ++++++
 tb/tb_if_fetch.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, encodings and bus layouts for the IF stage and its neighbours on the IF/ID boundary.
// The constants mirror the pipeline-wide stall and bus definitions so every stage agrees on bit positions.
package if_fetch_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC_VAL = 32'hBFC0_0000;
    localparam logic [31:0] PC_STEP_VAL  = 32'd4;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

    // Sequential successor; the adder is 32 bits wide, so the result wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/if_fetch_pc_redirect.sv
// Next-PC selection plus a one-entry store for redirects that arrive while IF is stalled.
// Combinational next_pc, one-cycle pending store; a stalled IF keeps the newest redirect until it advances.
module if_fetch_pc_redirect
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] PC_STEP = PC_STEP_VAL
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_if,
    input  br_bus_t     i_br_bus,
    input  logic [31:0] i_pc,
    output logic [31:0] o_next_pc
);

    logic        r_pend_v;
    logic [31:0] r_pend_addr;

    // Any advance consumes the pending entry, whether or not a live branch won the selection.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pend_v    <= 1'b0;
            r_pend_addr <= 32'd0;
        end else if (i_stall_if == NO_STOP) begin
            r_pend_v    <= 1'b0;
        end else if (i_br_bus.br_e) begin
            r_pend_v    <= 1'b1;
            r_pend_addr <= i_br_bus.br_addr;
        end
    end

    always_comb begin
        o_next_pc = seq_pc(i_pc, PC_STEP);
        if (i_br_bus.br_e) begin
            o_next_pc = i_br_bus.br_addr;
        end else if (r_pend_v) begin
            o_next_pc = r_pend_addr;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, drives the instruction SRAM request and packs {ce, pc} for ID (fetch visible the cycle after the loading edge).
// A stalled IF holds PC and ce so the SRAM address and rdata stay stable for a held ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_VAL,
    parameter logic [31:0] PC_STEP  = PC_STEP_VAL
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [STALL_W-1:0]     i_stall,
    input  logic [BR_WD-1:0]       i_br_bus,
    output logic [IF_TO_ID_WD-1:0] o_if_to_id_bus,
    output logic                   o_inst_sram_en,
    output logic [3:0]             o_inst_sram_wen,
    output logic [31:0]            o_inst_sram_addr,
    output logic [31:0]            o_inst_sram_wdata
);

    logic [31:0] r_pc;
    logic        r_ce;
    logic [31:0] w_next_pc;
    logic        w_stall_if;
    br_bus_t     w_br_bus;
    if_to_id_t   w_if_to_id;
    logic        w_stall_unused;

    assign w_stall_if     = i_stall[0];
    assign w_br_bus       = br_bus_t'(i_br_bus);
    assign w_stall_unused = |i_stall[STALL_W-1:1];

    if_fetch_pc_redirect #(
        .PC_STEP (PC_STEP)
    ) u_redirect (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_stall_if (w_stall_if),
        .i_br_bus   (w_br_bus),
        .i_pc       (r_pc),
        .o_next_pc  (w_next_pc)
    );

    // Reset parks the PC one step before RESET_PC so the first advance reads as a normal sequential fetch.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_pc <= RESET_PC - PC_STEP;
            r_ce <= 1'b0;
        end else if (w_stall_if == NO_STOP) begin
            r_pc <= w_next_pc;
            r_ce <= 1'b1;
        end
    end

    always_comb begin
        w_if_to_id    = '0;
        w_if_to_id.ce = r_ce;
        w_if_to_id.pc = r_pc;
    end

    assign o_if_to_id_bus    = w_if_to_id;
    assign o_inst_sram_en    = r_ce;
    assign o_inst_sram_wen   = 4'b0000;
    assign o_inst_sram_addr  = r_pc;
    assign o_inst_sram_wdata = 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Directed plan scenarios followed by a randomized run, all checked against a behavioural fetch model.
module tb_if_fetch;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;

    int total;
    int bad;

    // Model: the fetch address and validity ID would see, plus the remembered redirect target.
    logic [31:0] m_pc;
    logic        m_ce;
    logic        m_has_target;
    logic [31:0] m_target;

    if_fetch dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_br_bus          (br_bus),
        .o_if_to_id_bus    (if_to_id_bus),
        .o_inst_sram_en    (sram_en),
        .o_inst_sram_wen   (sram_wen),
        .o_inst_sram_addr  (sram_addr),
        .o_inst_sram_wdata (sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_pc         = RST_PC - 32'd4;
            m_ce         = 1'b0;
            m_has_target = 1'b0;
            m_target     = 32'd0;
        end else if (!stall[0]) begin
            if (br_bus[32])        m_pc = br_bus[31:0];
            else if (m_has_target) m_pc = m_target;
            else                   m_pc = m_pc + 32'd4;
            m_ce         = 1'b1;
            m_has_target = 1'b0;
        end else if (br_bus[32]) begin
            m_has_target = 1'b1;
            m_target     = br_bus[31:0];
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".en"},    {63'd0, sram_en}, {63'd0, m_ce});
        chk({tag, ".addr"},  {32'd0, sram_addr}, {32'd0, m_pc});
        chk({tag, ".bus"},   {31'd0, if_to_id_bus}, {31'd0, m_ce, m_pc});
        chk({tag, ".const"}, {28'd0, sram_wen, sram_wdata}, 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic be, input logic [31:0] ba);
        rst    = r;
        stall  = {5'b10101 & 5'($urandom), s};
        br_bus = {be, ba};
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] exp_addr);
        chk(tag, {31'd0, sram_en, sram_addr}, {31'd0, 1'b1, exp_addr});
    endtask

    logic [31:0] p;

    initial begin
        total = 0;
        bad   = 0;
        m_pc = '0; m_ce = 1'b0; m_has_target = 1'b0; m_target = '0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        #1;

        // Reset then free-run
        step(); step();
        chk("reset.en", {63'd0, sram_en}, 64'd0);
        chk("reset.bus", {31'd0, if_to_id_bus}, {31'd0, 1'b0, RST_PC - 32'd4});
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("run0", 32'hBFC0_0000);
        step(); chk_addr("run1", 32'hBFC0_0004);
        step(); chk_addr("run2", 32'hBFC0_0008);

        // Taken branch
        drive(1'b1, 1'b0, 1'b1, 32'hBFC0_0100);
        step(); chk_addr("br.tgt", 32'hBFC0_0100);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("br.seq", 32'hBFC0_0104);

        // Stall hold
        p = sram_addr;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); chk_addr("stall.hold", p);
        end
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("stall.rel", p + 32'd4);

        // Branch during stall
        p = sram_addr;
        drive(1'b1, 1'b1, 1'b1, 32'h8000_1000);
        step(); chk_addr("bstall.hold0", p);
        drive(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step(); step(); chk_addr("bstall.hold1", p);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("bstall.adv", 32'h8000_1000);
        step(); chk_addr("bstall.clr", 32'h8000_1004);

        // Double redirect during stall
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0100); step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0200); step();
        drive(1'b1, 1'b1, 1'b0, 32'd0);         step();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("dbl.adv", 32'h0000_0200);

        // Live branch beats pending target at the advance edge
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0200); step();
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0300);
        step(); chk_addr("live.win", 32'h0000_0300);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("live.seq", 32'h0000_0304);

        // Reset mid-stall with pending redirect
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0500); step();
        drive(1'b0, 1'b1, 1'b0, 32'd0);
        step();
        chk("rststall.en", {63'd0, sram_en}, 64'd0);
        chk("rststall.pc", {32'd0, sram_addr}, {32'd0, RST_PC - 32'd4});
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("rststall.first", 32'hBFC0_0000);
        step(); chk_addr("rststall.next", 32'hBFC0_0004);

        // Wrap-around of the sequential increment
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC); step();
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        step(); chk_addr("wrap", 32'h0000_0000);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) >= 3),
                  ($urandom_range(0, 99) < 35),
                  ($urandom_range(0, 99) < 20),
                  $urandom());
            step();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
